// File: rtl/booth_div_top_1.sv
// Sequential signed divider: 24-bit dividend / 12-bit divisor, one restoring step per clock
// on operand magnitudes, followed by a sign-fix cycle that also applies div-by-zero/overflow saturation.
module booth_div_top_1 #(
   parameter int DIVIDEND_W = 24,
   parameter int DIVISOR_W  = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  busy,
   output logic                  result_rdy,
   output logic                  div_zero,
   output logic                  ovf
);
   localparam int CW = $clog2(DIVIDEND_W);
   localparam logic [DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
   localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};
   localparam logic [CW-1:0]         LAST  = CW'(DIVIDEND_W-1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t                state;
   logic [DIVIDEND_W-1:0] dq;      // dividend magnitude shifting out, quotient bits shifting in
   logic [DIVISOR_W:0]    dvs;
   logic [DIVISOR_W:0]    prem;
   logic [CW-1:0]         cnt;
   logic                  q_neg, d_neg, dz_p, ovf_p;

   logic [DIVIDEND_W-1:0] a_mag;
   logic [DIVISOR_W:0]    b_ext, b_mag;
   logic [DIVISOR_W+1:0]  shifted, trial;

   // |min dividend| wraps to itself, which is the correct unsigned magnitude
   always_comb begin
      a_mag   = dividend[DIVIDEND_W-1] ? -dividend : dividend;
      b_ext   = {divisor[DIVISOR_W-1], divisor};
      b_mag   = divisor[DIVISOR_W-1] ? -b_ext : b_ext;
      shifted = {prem, dq[DIVIDEND_W-1]};
      trial   = shifted - {1'b0, dvs};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dq         <= '0;
         dvs        <= '0;
         prem       <= '0;
         cnt        <= '0;
         q_neg      <= 1'b0;
         d_neg      <= 1'b0;
         dz_p       <= 1'b0;
         ovf_p      <= 1'b0;
         quotient   <= '0;
         remainder  <= '0;
         busy       <= 1'b0;
         result_rdy <= 1'b0;
         div_zero   <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               result_rdy <= 1'b0;
               if (en) begin
                  dq    <= a_mag;
                  dvs   <= b_mag;
                  prem  <= '0;
                  cnt   <= '0;
                  d_neg <= dividend[DIVIDEND_W-1];
                  q_neg <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                  dz_p  <= (divisor == '0);
                  ovf_p <= (dividend == Q_MIN) && (divisor == '1);
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               dq   <= {dq[DIVIDEND_W-2:0], ~trial[DIVISOR_W+1]};
               prem <= trial[DIVISOR_W+1] ? shifted[DIVISOR_W:0] : trial[DIVISOR_W:0];
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) state <= FIX;
            end
            FIX: begin
               if (dz_p) begin
                  quotient  <= d_neg ? Q_MIN : Q_MAX;
                  remainder <= '0;
               end else if (ovf_p) begin
                  quotient  <= Q_MAX;
                  remainder <= '0;
               end else begin
                  quotient  <= q_neg ? -dq : dq;
                  remainder <= d_neg ? -prem[DIVISOR_W-1:0] : prem[DIVISOR_W-1:0];
               end
               div_zero   <= dz_p;
               ovf        <= ovf_p & ~dz_p;
               result_rdy <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_div_top_1.sv
// Scoreboard bench for booth_div_top_1: stimulus pushes model results, a negedge monitor
// pops and compares them (value, flags, latency) whenever result_rdy is seen.
module tb_booth_div_top_1;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [23:0] dividend = '0;
   logic [11:0] divisor = '0;
   logic [23:0] quotient;
   logic [11:0] remainder;
   logic        busy, result_rdy, div_zero, ovf;

   typedef struct {
      logic [23:0] q;
      logic [11:0] r;
      logic        dz;
      logic        ov;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic prev_rdy = 1'b0;

   booth_div_top_1 dut (
      .clk(clk), .rst_n(rst_n), .en(en), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .busy(busy),
      .result_rdy(result_rdy), .div_zero(div_zero), .ovf(ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Plain integer arithmetic: SV '/' truncates toward zero and '%' follows the dividend sign
   function automatic exp_t model(input logic [23:0] a, input logic [11:0] b);
      exp_t e;
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      e.dz = 1'b0; e.ov = 1'b0; e.cyc = 0;
      if (sb == 0) begin
         e.q  = (sa < 0) ? 24'h800000 : 24'h7FFFFF;
         e.r  = '0;
         e.dz = 1'b1;
      end else if (sa == -8388608 && sb == -1) begin
         e.q  = 24'h7FFFFF;
         e.r  = '0;
         e.ov = 1'b1;
      end else begin
         e.q = 24'(sa / sb);
         e.r = 12'(sa % sb);
      end
      return e;
   endfunction

   // Called at a negedge; drives en while idle (incl. the result_rdy cycle) and records accept time
   task automatic start_op(input logic [23:0] a, input logic [11:0] b);
      exp_t e;
      int   n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 32'(busy), 32'd0);
      en = 1'b1; dividend = a; divisor = b;
      @(posedge clk);
      #1;
      e = model(a, b);
      e.cyc = cyc;
      sb_q.push_back(e);
      @(negedge clk);
      en = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (result_rdy) begin
            chk("rdy_one_cycle", 32'(prev_rdy), 32'd0);
            if (sb_q.size() == 0) begin
               chk("unexpected_result", 32'(result_rdy), 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("quotient", 32'(quotient), 32'(e.q));
               chk("remainder", 32'(remainder), 32'(e.r));
               chk("div_zero", 32'(div_zero), 32'(e.dz));
               chk("ovf", 32'(ovf), 32'(e.ov));
               chk("latency", 32'(cyc), 32'(e.cyc + 25));
               chk("busy_at_result", 32'(busy), 32'd0);
            end
         end
         prev_rdy <= result_rdy;
      end else begin
         prev_rdy <= 1'b0;
      end
   end

   initial begin
      logic [23:0] a;
      logic [11:0] b;
      int n;
      repeat (3) @(negedge clk);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdy", 32'(result_rdy), 32'd0);
      chk("rst_flags", 32'({div_zero, ovf}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      start_op(24'd1000, 12'd7);
      start_op(24'hFFFC18, 12'd7);
      start_op(24'd1000, 12'hFF9);
      start_op(24'd1234, 12'd0);
      start_op(24'hFFFFFB, 12'd0);
      start_op(24'h800000, 12'hFFF);
      start_op(24'h800000, 12'd2);
      start_op(24'h800000, 12'd1);
      start_op(24'h7FFFFF, 12'h800);

      // en pulses with other operands while busy must not disturb the running op
      start_op(24'd777777, 12'd13);
      repeat (2) @(negedge clk);
      en = 1'b1; dividend = 24'd5; divisor = 12'd1;
      @(negedge clk);
      en = 1'b0;
      repeat (6) @(negedge clk);
      en = 1'b1; dividend = 24'hABCDEF; divisor = 12'd3;
      @(negedge clk);
      en = 1'b0;
      start_op(24'hF00000, 12'd100);

      for (int i = 0; i < 30; i++) begin
         a = 24'($urandom);
         case ($urandom_range(0, 5))
            0: b = 12'd0;
            1: b = 12'hFFF;
            2: b = 12'($urandom_range(1, 15));
            default: b = 12'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) a = 24'h800000;
         start_op(a, b);
      end

      // Asynchronous reset mid-operation: outputs clear immediately, aborted op never reports
      start_op(24'd5000, 12'd3);
      repeat (11) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_quotient", 32'(quotient), 32'd0);
      chk("async_rst_remainder", 32'(remainder), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_rdy_flags", 32'({result_rdy, div_zero, ovf}), 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      start_op(24'd100, 12'd10);

      n = 0;
      while (sb_q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() > 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
